mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  Multi-cycle multiply/divide unit sitting beside the ALU in the E stage; it serves the
//  HI/LO instruction class (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) issued by decode.
//  It holds HI/LO state, models fixed multiply/divide latency and exposes busy so the
//  hazard unit can stall later HI/LO-class instructions.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   instruction in E stage targets MDU this cycle
//  op        in   4   MDU op code (shared defines, see STRUCTURE)
//  src_a     in   32  rs value (forwarded)
//  src_b     in   32  rt value (forwarded)
//  busy      out  1   multi-cycle operation in progress
//  hi        out  32  architectural HI register
//  lo        out  32  architectural LO register
//  rd_data   out  32  mfhi -> hi, mflo -> lo, otherwise 0 (combinational on op)
// BEHAVIOUR
//  - Reset (rst_n low, any time incl. mid-operation): hi=0, lo=0, busy=0, counter=0,
//    pending results discarded; state IDLE. Takes effect without a clock edge.
//  - States: IDLE, BUSY. Counter cnt, width sized for max(MULT_CYCLES,DIV_CYCLES).
//  - IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}: at edge k capture products/quotients
//    into pending_hi/pending_lo, load cnt=N (MULT_CYCLES or DIV_CYCLES), go BUSY.
//    busy=1 for cycles k+1..k+N; HI/LO written at edge ending cycle k+N; busy=0 and new
//    HI/LO visible on outputs from cycle k+N+1.
//  - BUSY: cnt decrements each edge; cnt==1 -> commit pending, return to IDLE.
//  - start while busy=1 is ignored (hazard unit guarantees it stalls; bench asserts it).
//  - MTHI/MTLO with start=1 in IDLE: hi<=src_a / lo<=src_a at that edge, no busy.
//  - MFHI/MFLO: no state change; rd_data reflects current hi/lo (never pending values).
//  - MULT: {hi,lo}=signed(src_a)*signed(src_b), 64-bit. MULTU: unsigned 64-bit.
//  - DIV: lo=signed quotient, hi=signed remainder (truncate toward zero, remainder takes
//    dividend sign). DIVU: unsigned.
//  - Divide by zero: operation still takes DIV_CYCLES busy; hi/lo left unchanged.
//  - Signed overflow 0x80000000/-1: lo=0x80000000, hi=0.
//  - op=NONE or start=0: no effect. Unknown op codes: treated as NONE.
// STRUCTURE
//  - Shared define file mdu_defines.v: MDU op codes NONE=0 MULT=1 MULTU=2 DIV=3 DIVU=4
//    MTHI=5 MTLO=6 MFHI=7 MFLO=8; also included by the controller that drives op.
//  - One natural sub-module: mdu_calc (purely combinational, op/src_a/src_b ->
//    {res_hi,res_lo}, owns signed/unsigned and div-by-zero rules). mdu_unit owns FSM,
//    counter, pending and HI/LO registers.
// TESTING
//  1 Reset: rst_n low mid-mult (cycle 3 of 5) -> busy=0, hi=lo=0 immediately, no commit.
//  2 MULT src_a=0xFFFFFFFE(-2), src_b=3 -> busy exactly 5 cycles, then hi=0xFFFFFFFF,
//    lo=0xFFFFFFFA; MULTU same inputs -> hi=0x00000002, lo=0xFFFFFFFA.
//  3 DIV src_a=-7, src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1);
//    DIVU 7/2 -> lo=3, hi=1.
//  4 MTHI 0x12345678 then MFHI next cycle -> rd_data=0x12345678, busy never set.
//  5 DIV by 0 after MTLO 0xA5A5A5A5 -> busy 10 cycles, lo stays 0xA5A5A5A5, hi unchanged.
//  6 start=MTLO while busy -> ignored, lo gets only the committed multiply result;
//    MFLO during busy returns old lo.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states and the
// result bundle passed from the arithmetic datapath to the control block.
package mdu_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // ok=0 means the result must not be committed (divide by zero).
    typedef struct packed {
        logic            ok;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_res_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Request/response bundle between the E-stage controller and the MDU.
// start is a one-cycle request, accepted only while busy is low; a start seen while
// busy is high is dropped, so the hazard unit must stall HI/LO-class ops until busy falls.
interface mdu_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, src_a, src_b,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, hi, lo, rd_data
    );
endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing {hi,lo}; owns the signed/unsigned
// handling and suppresses the commit on divide by zero.
module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output mdu_res_t    res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide runs on magnitudes; 0x80000000/-1 then wraps back to 0x80000000, rem 0.
    assign signed_div = (op == OP_DIV);
    assign neg_a      = signed_div & src_a[31];
    assign neg_b      = signed_div & src_b[31];
    assign mag_a      = neg_a ? (32'd0 - src_a) : src_a;
    assign mag_b      = neg_b ? (32'd0 - src_b) : src_b;
    assign div_b      = (src_b == 32'd0) ? 32'd1 : mag_b;
    assign quo_mag    = mag_a / div_b;
    assign rem_mag    = mag_a % div_b;
    assign quo        = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
    assign rem        = neg_a ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        res = '0;
        case (op)
            OP_MULT: begin
                res.ok = 1'b1;
                res.hi = prod_s[63:32];
                res.lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res.ok = 1'b1;
                res.hi = prod_u[63:32];
                res.lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res.ok = (src_b != 32'd0);
                res.hi = rem;
                res.lo = quo;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit: holds architectural HI/LO, models fixed mult/div latency
// with a down-counter and reports busy so later HI/LO-class instructions can stall.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_unit_if.slave   bus,
    output mdu_state_e  dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;
    logic [31:0] pend_hi, pend_hi_nxt;
    logic [31:0] pend_lo, pend_lo_nxt;
    logic        pend_ok, pend_ok_nxt;
    logic        accept;
    mdu_res_t    calc_res;

    mdu_calc u_calc (
        .op    (bus.op),
        .src_a (bus.src_a),
        .src_b (bus.src_b),
        .res   (calc_res)
    );

    assign accept = bus.start && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_ok <= pend_ok_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_ok_nxt = pend_ok;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
                        pend_hi_nxt = calc_res.hi;
                        pend_lo_nxt = calc_res.lo;
                        pend_ok_nxt = calc_res.ok;
                        cnt_nxt     = is_mul_op(bus.op) ? CNT_W'(MULT_CYCLES)
                                                        : CNT_W'(DIV_CYCLES);
                        state_nxt   = ST_BUSY;
                    end else if (bus.op == OP_MTHI) begin
                        hi_nxt = bus.src_a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_nxt = bus.src_a;
                    end
                end
            end
            ST_BUSY: begin
                // Last busy cycle: pending result becomes architectural at this edge.
                if (cnt == CNT_W'(1)) begin
                    if (pend_ok) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                    pend_ok_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.op == OP_MFHI) begin
            bus.rd_data = hi_q;
        end else if (bus.op == OP_MFLO) begin
            bus.rd_data = lo_q;
        end
    end

    assign bus.busy  = (state == ST_BUSY);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: expected HI/LO results are queued when an op is issued
// and popped when busy falls; busy length, reset and MF/MT behaviour are checked inline.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    mdu_state_e dbg_state;
    int         tests = 0;
    int         fails = 0;
    logic [63:0] exp_q[$];

    mdu_unit_if bus ();

    mdu_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
    endtask

    task automatic short_op(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        drive(op, a, 32'd0);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic long_op(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int n);
        logic [63:0] exp;
        int busy_cycles;
        busy_cycles = 0;
        exp_q.push_back({exp_hi, exp_lo});
        @(negedge clk);
        drive(op, a, b);
        @(negedge clk);
        idle_inputs();
        while (bus.busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(n));
        exp = exp_q.pop_front();
        check({tag, " hi"}, bus.hi, exp[63:32]);
        check({tag, " lo"}, bus.lo, exp[31:0]);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prod;
        logic [63:0] exp;
        int busy_cycles;

        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of a multiply
        short_op(OP_MTHI, 32'hDEAD_BEEF);
        short_op(OP_MTLO, 32'h0BAD_F00D);
        check("mthi value", bus.hi, 32'hDEAD_BEEF);
        check("mtlo value", bus.lo, 32'h0BAD_F00D);
        @(negedge clk);
        drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        repeat (3) @(negedge clk);
        idle_inputs();
        check("rst mid busy before", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid busy", {31'd0, bus.busy}, 32'd0);
        check("rst mid hi", bus.hi, 32'd0);
        check("rst mid lo", bus.lo, 32'd0);
        check("rst mid state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst no commit hi", bus.hi, 32'd0);
        check("rst no commit lo", bus.lo, 32'd0);
        check("rst no commit busy", {31'd0, bus.busy}, 32'd0);

        // multiply / divide
        long_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N);
        long_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MULT_N);
        long_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
        long_op("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DIV_N);
        long_op("div neg divisor", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_N);
        long_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_N);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            prod = {32'd0, ra} * {32'd0, rb};
            long_op("rand multu", OP_MULTU, ra, rb, prod[63:32], prod[31:0], MULT_N);
            rb = 32'($urandom_range(1, 65535));
            long_op("rand divu", OP_DIVU, ra, rb, ra % rb, ra / rb, DIV_N);
        end

        // MTHI then MFHI
        @(negedge clk);
        drive(OP_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        drive(OP_MFHI, 32'd0, 32'd0);
        #1;
        check("mfhi rd_data", bus.rd_data, 32'h1234_5678);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mfhi busy", {31'd0, bus.busy}, 32'd0);
        check("rd_data none", bus.rd_data, 32'd0);

        // unknown op code behaves as NONE
        @(negedge clk);
        drive(4'hF, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        idle_inputs();
        check("unknown op busy", {31'd0, bus.busy}, 32'd0);
        check("unknown op hi", bus.hi, 32'h1234_5678);

        // divide by zero leaves HI/LO alone
        short_op(OP_MTLO, 32'hA5A5_A5A5);
        long_op("div0", OP_DIV, 32'd5, 32'd0, 32'h1234_5678, 32'hA5A5_A5A5, DIV_N);

        // MTLO while busy is dropped; MFLO while busy sees old LO
        exp_q.push_back({32'd0, 32'd42});
        @(negedge clk);
        drive(OP_MULT, 32'd6, 32'd7);
        @(negedge clk);
        drive(OP_MTLO, 32'h0000_0BAD, 32'd0);
        #1;
        check("busy during mtlo", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        drive(OP_MFLO, 32'd0, 32'd0);
        #1;
        check("mflo during busy", bus.rd_data, 32'hA5A5_A5A5);
        busy_cycles = 2;
        @(negedge clk);
        idle_inputs();
        while (bus.busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("mult w/ mtlo busy_cycles", 32'(busy_cycles), 32'(MULT_N));
        exp = exp_q.pop_front();
        check("mult w/ mtlo hi", bus.hi, exp[63:32]);
        check("mult w/ mtlo lo", bus.lo, exp[31:0]);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
